// File: rtl/eeprom_arb_pkg.sv
// Shared types and constants for the two-port EEPROM controller arbiter.
// Optional timeout logic is enabled with the EEPROM_ARB_TIMEOUT_EN macro.
package eeprom_arb_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;
    localparam logic [DATA_W-1:0] TIMEOUT_READDATA = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        GRANT_A,
        GRANT_B,
        ABORT
    } arb_state_t;

    typedef enum logic {
        REQ_A,
        REQ_B
    } req_id_t;

    typedef struct packed {
        logic              rd;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } eep_cmd_t;

    // A requester raising read and write together is served as a write.
    function automatic eep_cmd_t make_cmd(input logic              read,
                                          input logic              write,
                                          input logic [ADDR_W-1:0] addr,
                                          input logic [DATA_W-1:0] data);
        eep_cmd_t c;
        c.rd   = read & ~write;
        c.wr   = write;
        c.addr = addr;
        c.data = data;
        return c;
    endfunction

endpackage

// File: rtl/eeprom_arb_timer.sv
// Clear/enable cycle counter; expired is high once LIMIT enabled cycles have
// been counted since the last clear. Used only with EEPROM_ARB_TIMEOUT_EN.
module eeprom_arb_timer #(
    parameter int unsigned LIMIT = 2_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned W = $clog2(LIMIT + 1);

    logic [W-1:0] count;

    // NOTE: sequential state is assigned with non-blocking (<=) so every
    // flop samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

    // Count is 0 in the first enabled cycle, so this flags the LIMIT-th one.
    assign expired = (count == W'(LIMIT - 1));

endmodule

// File: rtl/eeprom_arbiter.sv
// Round-robin arbiter sharing the EEPROM controller Avalon-MM port between
// requesters A and B. Define EEPROM_ARB_TIMEOUT_EN for the downstream timeout.
module eeprom_arbiter
    import eeprom_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
    input  logic              csi_clk,
    input  logic              rsi_reset,

    input  logic              avs_a_read,
    input  logic              avs_a_write,
    input  logic [ADDR_W-1:0] avs_a_address,
    input  logic [DATA_W-1:0] avs_a_writedata,
    output logic [DATA_W-1:0] avs_a_readdata,
    output logic              avs_a_waitrequest,

    input  logic              avs_b_read,
    input  logic              avs_b_write,
    input  logic [ADDR_W-1:0] avs_b_address,
    input  logic [DATA_W-1:0] avs_b_writedata,
    output logic [DATA_W-1:0] avs_b_readdata,
    output logic              avs_b_waitrequest,

    output logic              avm_eep_read,
    output logic              avm_eep_write,
    output logic [ADDR_W-1:0] avm_eep_address,
    output logic [DATA_W-1:0] avm_eep_writedata,
    input  logic [DATA_W-1:0] avm_eep_readdata,
    input  logic              avm_eep_waitrequest,

    output logic              coe_conduit_timeout
);

    arb_state_t        state, state_nxt;
    req_id_t           last_grant, last_grant_nxt;
    eep_cmd_t          cmd_q, cmd_nxt;
    logic              cpl;
    logic [DATA_W-1:0] cpl_data;
    logic              req_a, req_b;

    assign req_a = avs_a_read | avs_a_write;
    assign req_b = avs_b_read | avs_b_write;

`ifdef EEPROM_ARB_TIMEOUT_EN
    logic timeout_q, timeout_nxt;
    logic in_grant;
    logic expired;

    assign in_grant = (state == GRANT_A) || (state == GRANT_B);

    eeprom_arb_timer #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (csi_clk),
        .rst_n  (rsi_reset),
        .clear  (!in_grant),
        .enable (in_grant),
        .expired(expired)
    );

    always_ff @(posedge csi_clk or negedge rsi_reset) begin
        if (!rsi_reset) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_nxt;
        end
    end

    assign coe_conduit_timeout = timeout_q;
`else
    // The timeout parameter has no effect when the timeout logic is compiled out.
    if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
    end

    assign coe_conduit_timeout = 1'b0;
`endif

    // Holding the latched command in the state register makes the downstream
    // command drop together with state on an asynchronous reset.
    always_ff @(posedge csi_clk or negedge rsi_reset) begin
        if (!rsi_reset) begin
            state      <= IDLE;
            last_grant <= REQ_B;
            cmd_q      <= '0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            cmd_q      <= cmd_nxt;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        cmd_nxt        = cmd_q;
        cpl            = 1'b0;
        cpl_data       = avm_eep_readdata;
`ifdef EEPROM_ARB_TIMEOUT_EN
        timeout_nxt    = timeout_q;
`endif
        case (state)
            IDLE: begin
                if (req_a && (!req_b || last_grant == REQ_B)) begin
                    state_nxt      = GRANT_A;
                    last_grant_nxt = REQ_A;
                    cmd_nxt        = make_cmd(avs_a_read, avs_a_write,
                                              avs_a_address, avs_a_writedata);
                end else if (req_b) begin
                    state_nxt      = GRANT_B;
                    last_grant_nxt = REQ_B;
                    cmd_nxt        = make_cmd(avs_b_read, avs_b_write,
                                              avs_b_address, avs_b_writedata);
                end
            end
            // last_grant names the owner throughout GRANT_x and ABORT.
            GRANT_A, GRANT_B: begin
                if (!avm_eep_waitrequest) begin
                    cpl        = 1'b1;
                    state_nxt  = IDLE;
                    cmd_nxt.rd = 1'b0;
                    cmd_nxt.wr = 1'b0;
`ifdef EEPROM_ARB_TIMEOUT_EN
                    timeout_nxt = 1'b0;
`endif
                end
`ifdef EEPROM_ARB_TIMEOUT_EN
                else if (expired) begin
                    state_nxt   = ABORT;
                    cmd_nxt.rd  = 1'b0;
                    cmd_nxt.wr  = 1'b0;
                    timeout_nxt = 1'b1;
                end
`endif
            end
`ifdef EEPROM_ARB_TIMEOUT_EN
            ABORT: begin
                cpl       = 1'b1;
                cpl_data  = TIMEOUT_READDATA;
                state_nxt = IDLE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    assign avs_a_waitrequest = !(cpl && last_grant == REQ_A);
    assign avs_b_waitrequest = !(cpl && last_grant == REQ_B);
    assign avs_a_readdata    = (cpl && last_grant == REQ_A) ? cpl_data : '0;
    assign avs_b_readdata    = (cpl && last_grant == REQ_B) ? cpl_data : '0;

    assign avm_eep_read      = cmd_q.rd;
    assign avm_eep_write     = cmd_q.wr;
    assign avm_eep_address   = cmd_q.addr;
    assign avm_eep_writedata = cmd_q.data;

endmodule

// File: tb/tb_eeprom_arbiter.sv
// Self-checking bench for eeprom_arbiter: vector table, corner sequences and a
// randomized run against a transaction-level model of the arbitration rules.
module tb_eeprom_arbiter;

    localparam int TO = 16;

    logic        csi_clk = 1'b0;
    logic        rsi_reset = 1'b0;
    logic        avs_a_read = 1'b0, avs_a_write = 1'b0;
    logic [15:0] avs_a_address = '0;
    logic [7:0]  avs_a_writedata = '0;
    logic [7:0]  avs_a_readdata;
    logic        avs_a_waitrequest;
    logic        avs_b_read = 1'b0, avs_b_write = 1'b0;
    logic [15:0] avs_b_address = '0;
    logic [7:0]  avs_b_writedata = '0;
    logic [7:0]  avs_b_readdata;
    logic        avs_b_waitrequest;
    logic        avm_eep_read, avm_eep_write;
    logic [15:0] avm_eep_address;
    logic [7:0]  avm_eep_writedata;
    logic [7:0]  avm_eep_readdata = '0;
    logic        avm_eep_waitrequest = 1'b1;
    logic        coe_conduit_timeout;

    always #5 csi_clk = ~csi_clk;

    eeprom_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .csi_clk            (csi_clk),
        .rsi_reset          (rsi_reset),
        .avs_a_read         (avs_a_read),
        .avs_a_write        (avs_a_write),
        .avs_a_address      (avs_a_address),
        .avs_a_writedata    (avs_a_writedata),
        .avs_a_readdata     (avs_a_readdata),
        .avs_a_waitrequest  (avs_a_waitrequest),
        .avs_b_read         (avs_b_read),
        .avs_b_write        (avs_b_write),
        .avs_b_address      (avs_b_address),
        .avs_b_writedata    (avs_b_writedata),
        .avs_b_readdata     (avs_b_readdata),
        .avs_b_waitrequest  (avs_b_waitrequest),
        .avm_eep_read       (avm_eep_read),
        .avm_eep_write      (avm_eep_write),
        .avm_eep_address    (avm_eep_address),
        .avm_eep_writedata  (avm_eep_writedata),
        .avm_eep_readdata   (avm_eep_readdata),
        .avm_eep_waitrequest(avm_eep_waitrequest),
        .coe_conduit_timeout(coe_conduit_timeout)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input bit who, input bit rd, input bit wr,
                           input logic [15:0] addr, input logic [7:0] data);
        if (who) begin
            avs_b_read = rd; avs_b_write = wr; avs_b_address = addr; avs_b_writedata = data;
        end else begin
            avs_a_read = rd; avs_a_write = wr; avs_a_address = addr; avs_a_writedata = data;
        end
    endtask

    task automatic step();
        @(posedge csi_clk);
        #1;
    endtask

    typedef struct {
        bit          who;
        bit          rd;
        bit          wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
        int          stall;
        logic [7:0]  rdata;
        bit          exp_rd;
        bit          exp_wr;
    } xfer_t;

    // Single-requester transfer with a given downstream stall count.
    task automatic run_xfer(input xfer_t t);
        logic own_wait, oth_wait;
        logic [7:0] own_rd, oth_rd;
        set_req(t.who, t.rd, t.wr, t.addr, t.wdata);
        avm_eep_waitrequest = (t.stall > 0);
        avm_eep_readdata    = t.rdata;
        step();
        for (int c = 0; c <= t.stall; c++) begin
            avm_eep_waitrequest = (c < t.stall);
            #1;
            own_wait = t.who ? avs_b_waitrequest : avs_a_waitrequest;
            oth_wait = t.who ? avs_a_waitrequest : avs_b_waitrequest;
            own_rd   = t.who ? avs_b_readdata : avs_a_readdata;
            oth_rd   = t.who ? avs_a_readdata : avs_b_readdata;
            check("xfer eep_read", avm_eep_read, t.exp_rd);
            check("xfer eep_write", avm_eep_write, t.exp_wr);
            check("xfer eep_address", avm_eep_address, t.addr);
            check("xfer eep_writedata", avm_eep_writedata, t.wdata);
            check("xfer own_wait", own_wait, (c < t.stall));
            check("xfer other_wait", oth_wait, 1'b1);
            check("xfer other_readdata", oth_rd, 8'h00);
            if (c == t.stall) begin
                check("xfer own_readdata", own_rd, t.rdata);
                set_req(t.who, 1'b0, 1'b0, t.addr, t.wdata);
            end
            step();
        end
        check("xfer idle cmd", {avm_eep_read, avm_eep_write}, 2'b00);
        check("xfer idle waits", {avs_a_waitrequest, avs_b_waitrequest}, 2'b11);
    endtask

    // Transaction-level reference state for the random run.
    int          m_owner;
    bit          m_last;
    bit          m_rd, m_wr;
    logic [15:0] m_addr;
    logic [7:0]  m_data;
    bit          act[2], r_rd[2], r_wr[2], done[2];
    logic [15:0] r_addr[2];
    logic [7:0]  r_data[2];

    initial begin
        xfer_t vec[5];
        int lows;
        int stall_run;

        // Reset state
        #2;
        check("reset eep_cmd", {avm_eep_read, avm_eep_write}, 2'b00);
        check("reset eep_address", avm_eep_address, 16'h0000);
        check("reset eep_writedata", avm_eep_writedata, 8'h00);
        check("reset waits", {avs_a_waitrequest, avs_b_waitrequest}, 2'b11);
        check("reset readdata", {avs_a_readdata, avs_b_readdata}, 16'h0000);
        check("reset timeout", coe_conduit_timeout, 1'b0);
        repeat (3) @(negedge csi_clk);
        rsi_reset = 1'b1;

        // Tie from reset goes to A; A re-requesting while B waits loses to B.
        avm_eep_waitrequest = 1'b0;
        set_req(0, 0, 1, 16'h0A00, 8'h11);
        set_req(1, 0, 1, 16'h0B00, 8'h22);
        step();
        check("rr1 address", avm_eep_address, 16'h0A00);
        check("rr1 writedata", avm_eep_writedata, 8'h11);
        check("rr1 waits", {avs_a_waitrequest, avs_b_waitrequest}, 2'b01);
        set_req(0, 0, 1, 16'h0A01, 8'h33);
        step();
        check("rr gap cmd", avm_eep_write, 1'b0);
        check("rr gap waits", {avs_a_waitrequest, avs_b_waitrequest}, 2'b11);
        step();
        check("rr2 address", avm_eep_address, 16'h0B00);
        check("rr2 waits", {avs_a_waitrequest, avs_b_waitrequest}, 2'b10);
        set_req(1, 0, 0, 16'h0B00, 8'h22);
        step();
        check("rr gap2 cmd", avm_eep_write, 1'b0);
        step();
        check("rr3 address", avm_eep_address, 16'h0A01);
        check("rr3 waits", {avs_a_waitrequest, avs_b_waitrequest}, 2'b01);
        set_req(0, 0, 0, 16'h0A01, 8'h33);
        step();

        // Vector table of single-requester transfers
        vec[0] = '{0, 0, 1, 16'h0100, 8'h22, 5, 8'h00, 0, 1};
        vec[1] = '{1, 1, 0, 16'h0100, 8'h00, 0, 8'h55, 1, 0};
        vec[2] = '{0, 1, 1, 16'hBEEF, 8'h5A, 2, 8'h99, 0, 1};
        vec[3] = '{1, 0, 1, 16'hFFFF, 8'hFF, 1, 8'h00, 0, 1};
        vec[4] = '{0, 1, 0, 16'h0000, 8'h00, 0, 8'hA5, 1, 0};
        for (int i = 0; i < 5; i++) run_xfer(vec[i]);

        // Requester changes its inputs after the grant
        avm_eep_waitrequest = 1'b1;
        set_req(0, 1, 0, 16'h0100, 8'h00);
        step();
        check("hold address", avm_eep_address, 16'h0100);
        set_req(0, 0, 1, 16'h0200, 8'h77);
        step();
        check("hold address late", avm_eep_address, 16'h0100);
        check("hold cmd late", {avm_eep_read, avm_eep_write}, 2'b10);
        check("hold a_wait", avs_a_waitrequest, 1'b1);
        avm_eep_waitrequest = 1'b0;
        avm_eep_readdata    = 8'h3C;
        #1;
        check("hold completion", {avs_a_waitrequest, avs_a_readdata}, {1'b0, 8'h3C});
        check("hold address end", avm_eep_address, 16'h0100);
        set_req(0, 0, 0, 16'h0200, 8'h77);
        step();
        check("hold idle", avm_eep_read, 1'b0);

        // Asynchronous reset during GRANT_B, then tie goes to A
        avm_eep_waitrequest = 1'b1;
        set_req(1, 1, 0, 16'h0300, 8'h00);
        step();
        check("rst granted", avm_eep_read, 1'b1);
        #2 rsi_reset = 1'b0;
        #1;
        check("rst async read", avm_eep_read, 1'b0);
        check("rst async address", avm_eep_address, 16'h0000);
        set_req(1, 0, 0, 16'h0300, 8'h00);
        @(negedge csi_clk);
        rsi_reset = 1'b1;
        avm_eep_waitrequest = 1'b0;
        set_req(0, 1, 0, 16'h0400, 8'h00);
        set_req(1, 1, 0, 16'h0500, 8'h00);
        step();
        check("rst tie A", {avs_a_waitrequest, avs_b_waitrequest}, 2'b01);
        check("rst tie address", avm_eep_address, 16'h0400);
        set_req(0, 0, 0, 16'h0400, 8'h00);
        step();
        step();
        check("rst tie B next", {avs_a_waitrequest, avs_b_waitrequest}, 2'b10);
        set_req(1, 0, 0, 16'h0500, 8'h00);
        step();

`ifdef EEPROM_ARB_TIMEOUT_EN
        // Downstream stuck: completion by abort in cycle TO+1 after grant
        avm_eep_waitrequest = 1'b1;
        set_req(0, 0, 1, 16'h0123, 8'h44);
        step();
        lows = 0;
        for (int k = 1; k <= TO; k++) begin
            if (!avs_a_waitrequest) lows++;
            step();
        end
        check("timeout early completions", lows, 0);
        check("timeout a_wait", avs_a_waitrequest, 1'b0);
        check("timeout readdata", avs_a_readdata, 8'hFF);
        check("timeout flag", coe_conduit_timeout, 1'b1);
        check("timeout cmd dropped", avm_eep_write, 1'b0);
        set_req(0, 0, 0, 16'h0123, 8'h44);
        step();
        check("timeout flag sticky", coe_conduit_timeout, 1'b1);
        run_xfer('{1, 0, 1, 16'h0042, 8'h24, 0, 8'h00, 0, 1});
        check("timeout flag cleared", coe_conduit_timeout, 1'b0);
`endif

        // Randomized run against the reference model
        rsi_reset = 1'b0;
        set_req(0, 0, 0, '0, '0);
        set_req(1, 0, 0, '0, '0);
        @(negedge csi_clk);
        rsi_reset = 1'b1;
        m_owner = -1; m_last = 1'b1; m_rd = 1'b0; m_wr = 1'b0; m_addr = '0; m_data = '0;
        for (int x = 0; x < 2; x++) begin
            act[x] = 1'b0; done[x] = 1'b0; r_rd[x] = 1'b0; r_wr[x] = 1'b0;
            r_addr[x] = '0; r_data[x] = '0;
        end
        stall_run = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(posedge csi_clk);
            if (m_owner < 0) begin
                if (act[0] || act[1]) begin
                    int w;
                    w = (act[0] && act[1]) ? (m_last ? 0 : 1) : (act[0] ? 0 : 1);
                    m_addr  = r_addr[w];
                    m_data  = r_data[w];
                    m_wr    = r_wr[w];
                    m_rd    = r_rd[w] && !r_wr[w];
                    m_last  = (w == 1);
                    m_owner = w;
                end
            end else if (!avm_eep_waitrequest) begin
                m_owner = -1;
                m_rd    = 1'b0;
                m_wr    = 1'b0;
            end
            #1;
            for (int x = 0; x < 2; x++) begin
                if (done[x]) act[x] = 1'b0;
                if (!act[x] && $urandom_range(0, 3) == 0) begin
                    logic [1:0] k;
                    k = 2'($urandom_range(1, 3));
                    act[x] = 1'b1; r_rd[x] = k[0]; r_wr[x] = k[1];
                    r_addr[x] = 16'($urandom); r_data[x] = 8'($urandom);
                end
                set_req(x[0], act[x] && r_rd[x], act[x] && r_wr[x], r_addr[x], r_data[x]);
            end
            avm_eep_waitrequest = (stall_run >= 8) ? 1'b0 : ($urandom_range(0, 2) != 0);
            stall_run = avm_eep_waitrequest ? stall_run + 1 : 0;
            avm_eep_readdata = 8'($urandom);
            #1;
            check("rnd eep_read", avm_eep_read, m_rd);
            check("rnd eep_write", avm_eep_write, m_wr);
            check("rnd eep_address", avm_eep_address, m_addr);
            check("rnd eep_writedata", avm_eep_writedata, m_data);
            for (int x = 0; x < 2; x++) begin
                bit cpl;
                cpl = (m_owner == x) && !avm_eep_waitrequest;
                done[x] = cpl;
                check(x ? "rnd b_wait" : "rnd a_wait",
                      x ? avs_b_waitrequest : avs_a_waitrequest, !cpl);
                check(x ? "rnd b_readdata" : "rnd a_readdata",
                      x ? avs_b_readdata : avs_a_readdata, cpl ? avm_eep_readdata : 8'h00);
            end
            check("rnd timeout", coe_conduit_timeout, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/eeprom_arbiter.md
# eeprom_arbiter

Two-port arbiter that shares the single Avalon-MM data port of the I2C EEPROM controller between two requesters, e.g. the settings loader and the host CPU. Each requester sees an 8-bit data, 16-bit address Avalon slave with waitrequest. The arbiter grants round-robin, latches the winning command, and drives it onto the EEPROM controller port until that port drops waitrequest. It sits between the system interconnect and the EEPROM controller's s0 port.

## Interface
- TIMEOUT_CYCLES, 2_000_000: downstream waitrequest limit per transfer; 200 ms at 10 MHz. Used only with the timeout feature.
- csi_clk  in  1  system clock; all logic on rising edge.
- rsi_reset  in  1  asynchronous, active-low reset.
- avs_a_read / avs_a_write  in  1 each  requester A command.
- avs_a_address  in  16  requester A byte address.
- avs_a_writedata  in  8  requester A write data.
- avs_a_readdata  out  8  requester A read data; valid in the cycle avs_a_waitrequest is low.
- avs_a_waitrequest  out  1  requester A stall.
- avs_b_read, avs_b_write, avs_b_address, avs_b_writedata, avs_b_readdata, avs_b_waitrequest: same as A, for requester B.
- avm_eep_read / avm_eep_write  out  1 each  command to the EEPROM controller.
- avm_eep_address  out  16  registered address.
- avm_eep_writedata  out  8  registered write data.
- avm_eep_readdata  in  8  EEPROM read data.
- avm_eep_waitrequest  in  1  EEPROM controller stall.
- coe_conduit_timeout  out  1  sticky timeout flag.

## Operation
- States: IDLE, GRANT_A, GRANT_B, and with the timeout feature, ABORT.
- IDLE
  - Samples avs_x_read|avs_x_write.
  - If only one requester is active, go to its GRANT state.
  - If both are active, grant the one not recorded in last_grant.
  - On grant, latch address, writedata and command type into avm_eep_* registers, and update last_grant.
- Read and write asserted together by one requester: treated as a write.
- GRANT_x
  - avm_eep_read/write hold the latched command.
  - Inputs from the requester are ignored after the latch, so a requester that violates Avalon by changing or dropping its request mid-transfer does not disturb the downstream transfer.
  - Completion is the cycle avm_eep_waitrequest==0:
    - avs_x_waitrequest=0 (combinational from avm_eep_waitrequest).
    - avs_x_readdata=avm_eep_readdata (combinational).
    - Next state IDLE; avm_eep_read/write are cleared on that edge.
- The non-granted requester's waitrequest stays 1 while it requests.
- Each requester's waitrequest is 1 at all times except its own completion cycle.
- readdata to the non-completing requester is 8'h00.

## Timing
- Reset values: state=IDLE, last_grant=B (A wins the first tie), avm_eep_read/write=0, avm_eep_address=0, avm_eep_writedata=0, both avs_*_waitrequest=1, both avs_*_readdata=0, coe_conduit_timeout=0.
- Request asserted at edge N: grant latched at N+1, and avm_eep_* command is visible from N+1.
- Minimum transfer, with downstream waitrequest already low at N+1: completes in cycle N+1; 2 cycles total.
- One mandatory IDLE cycle between transfers, so back-to-back requests from A and B complete at least 2 cycles apart.
- Reset assertion mid-transfer clears everything immediately; the downstream command drops asynchronously.

## Configuration
- EEPROM_ARB_TIMEOUT_EN defined:
  - A cycle counter runs in GRANT_x, cleared on entering GRANT.
  - When the counter reaches TIMEOUT_CYCLES with downstream waitrequest still high, go to ABORT.
  - ABORT lasts 1 cycle: avm_eep_read/write=0, the granted requester completes with waitrequest=0 and readdata=8'hFF, coe_conduit_timeout is set, then IDLE.
  - coe_conduit_timeout clears on the next normal completion.
- EEPROM_ARB_TIMEOUT_EN undefined: no counter and no ABORT state; coe_conduit_timeout is tied 0; the arbiter waits indefinitely.

## Structure
- Package eeprom_arb_pkg holds:
  - the arb_state_t enum (IDLE, GRANT_A, GRANT_B, ABORT);
  - the req_id_t typedef (REQ_A, REQ_B);
  - localparams ADDR_W=16, DATA_W=8, TIMEOUT_READDATA=8'hFF.
- One sub-module, eeprom_arb_timer: clear/enable counter with an expired output, instantiated only under EEPROM_ARB_TIMEOUT_EN.

## Test plan
- A writes 0x22 to 0x0100 alone; downstream waitrequest held 5 cycles → avm_eep_write=1, address 0x0100, data 0x22 for 6 cycles; avs_a_waitrequest low exactly 1 cycle; B untouched.
- A and B request in the same cycle from reset → A served first, B second; next simultaneous pair → B served first, A second (round-robin).
- B reads 0x0100; downstream returns 0x55 → avs_b_readdata=0x55 in the completion cycle; avs_a_readdata stays 0x00.
- A changes address to 0x0200 one cycle after grant → avm_eep_address stays 0x0100 until completion.
- Reset driven low while in GRANT_B → avm_eep_read drops without waiting for a clock; after release, first tie goes to A.
- With EEPROM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, downstream waitrequest stuck high → requester completes at cycle 17 with readdata 0xFF and coe_conduit_timeout=1; the next good transfer clears the flag.
